// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the main-memory port arbiter and the DMA engine.
package mem_port_arbiter_pkg;

   localparam int ADDR_W_DEFAULT = 12;
   localparam int DATA_W_DEFAULT = 19;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter_2.sv
// Two-way round-robin winner select; ptr=0 favours port 0, ptr=1 favours port 1.
module rr_arbiter_2 (
   input  logic req0,
   input  logic req1,
   input  logic ptr,
   output logic any_req,
   output logic winner
);

   always_comb begin
      any_req = req0 | req1;
      winner  = (req0 & req1) ? ptr : req1;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single main memory between the CPU (port 0) and DMA (port 1).
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEFAULT,
   parameter int DATA_W  = DATA_W_DEFAULT,
   parameter int MEM_LAT = 2
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              REQ0,
   input  logic              WE0,
   input  logic [ADDR_W-1:0] ADDR0,
   input  logic [DATA_W-1:0] WDATA0,
   input  logic              REQ1,
   input  logic              WE1,
   input  logic [ADDR_W-1:0] ADDR1,
   input  logic [DATA_W-1:0] WDATA1,
   output logic              GNT0,
   output logic              GNT1,
   output logic              ACK0,
   output logic              ACK1,
   output logic [DATA_W-1:0] RDATA,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic              MEM_RD,
   output logic              MEM_WR,
   output logic [DATA_W-1:0] MEM_WDATA,
   input  logic [DATA_W-1:0] MEM_RDATA
);

   localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

   arb_state_t  state;
   logic [3:0]  cnt;
   logic        we_q;
   logic        sel_q;
   logic        ptr;

   logic              any_req;
   logic              winner;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

   rr_arbiter_2 u_rr (
      .req0    (REQ0),
      .req1    (REQ1),
      .ptr     (ptr),
      .any_req (any_req),
      .winner  (winner)
   );

   assign win_we    = winner ? WE1    : WE0;
   assign win_addr  = winner ? ADDR1  : ADDR0;
   assign win_wdata = winner ? WDATA1 : WDATA0;

   // Strobes are registered on the selection edge so they cover exactly MEM_LAT cycles.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         we_q      <= 1'b0;
         sel_q     <= 1'b0;
         ptr       <= 1'b0;
         GNT0      <= 1'b0;
         GNT1      <= 1'b0;
         ACK0      <= 1'b0;
         ACK1      <= 1'b0;
         MEM_RD    <= 1'b0;
         MEM_WR    <= 1'b0;
         MEM_ADDR  <= '0;
         MEM_WDATA <= '0;
         RDATA     <= '0;
      end else begin
         ACK0 <= 1'b0;
         ACK1 <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  sel_q     <= winner;
                  we_q      <= win_we;
                  MEM_ADDR  <= win_addr;
                  MEM_WDATA <= win_wdata;
                  MEM_RD    <= ~win_we;
                  MEM_WR    <= win_we;
                  GNT0      <= ~winner;
                  GNT1      <= winner;
                  cnt       <= '0;
                  state     <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               cnt <= cnt + 4'd1;
               if (cnt == LAST_CNT) begin
                  if (!we_q) RDATA <= MEM_RDATA;
                  MEM_RD <= 1'b0;
                  MEM_WR <= 1'b0;
                  ACK0   <= ~sel_q;
                  ACK1   <= sel_q;
                  state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               ptr   <= ~sel_q;
               GNT0  <= 1'b0;
               GNT1  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 4K x 19-bit main memory between two requesters: the CPU memory path (port 0) and a DMA/IO engine (port 1).
- Sequences each access as a multi-cycle read or write strobe with held address and data.
- Returns a one-cycle ACK with registered read data.
- Sits between the requesters and the memory's AR-address / MEM_RD / MEM_WR interface.

Parameters:
- ADDR_W, 12, memory address width (4K words).
- DATA_W, 19, memory word width.
- MEM_LAT, 2, cycles MEM_RD/MEM_WR are held per access; read data is sampled on the last of them; legal range 1..15.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ0  in  1  port 0 (CPU) request; held until ACK0.
- WE0  in  1  port 0: 1 = write, 0 = read.
- ADDR0  in  ADDR_W  port 0 address.
- WDATA0  in  DATA_W  port 0 write data.
- REQ1  in  1  port 1 (DMA) request; held until ACK1.
- WE1  in  1  port 1 write enable.
- ADDR1  in  ADDR_W  port 1 address.
- WDATA1  in  DATA_W  port 1 write data.
- GNT0  out  1  port 0 owns memory (ACCESS and DONE states).
- GNT1  out  1  port 1 owns memory.
- ACK0  out  1  one-cycle completion pulse, port 0.
- ACK1  out  1  one-cycle completion pulse, port 1.
- RDATA  out  DATA_W  read data; valid in the ACK cycle, then held until the next read completes.
- MEM_ADDR  out  ADDR_W  address to memory.
- MEM_RD  out  1  memory read strobe.
- MEM_WR  out  1  memory write strobe.
- MEM_WDATA  out  DATA_W  data to memory.
- MEM_RDATA  in  DATA_W  data from memory.

Behaviour:
- Reset (async, RST_N=0): state=IDLE; GNT0/1, ACK0/1, MEM_RD, MEM_WR = 0; MEM_ADDR, MEM_WDATA, RDATA = 0; round-robin pointer favours port 0. Strobes drop immediately on reset assertion, including mid-access. The aborted access gets no ACK.
- FSM has three states: IDLE, ACCESS, DONE.
- IDLE:
  - No REQ: stay in IDLE.
  - Exactly one REQ: select that port.
  - Both REQ: select the port the pointer favours.
  - On the selection edge: latch ADDR/WE/WDATA of the winner into MEM_ADDR/MEM_WDATA and an internal we flag; set GNTx; load cnt=0; go to ACCESS.
- ACCESS:
  - MEM_RD = ~we, MEM_WR = we, both registered outputs; MEM_ADDR and MEM_WDATA held constant.
  - cnt increments each cycle.
  - When cnt==MEM_LAT-1: for a read, RDATA <= MEM_RDATA; go to DONE, deasserting the strobe on that edge.
- DONE (exactly 1 cycle):
  - ACKx=1 for the granted port; GNTx stays 1.
  - Pointer set to favour the other port.
  - Next edge: GNTx=0, state=IDLE.
- Latency: REQ seen at edge N → strobe high cycles N+1..N+MEM_LAT → ACK in cycle N+MEM_LAT+1. Back-to-back throughput is one access per MEM_LAT+2 cycles.
- REQ withdrawn during ACCESS: the access completes and ACK still pulses. Requester inputs other than REQ are ignored after latch.
- REQ still high in the cycle after ACK: treated as a new request, re-arbitrated against the other port.
- MEM_RD and MEM_WR are never both 1. GNT0 and GNT1 are never both 1. At most one ACK per cycle.
- Writes leave RDATA unchanged.
- Address and data pass through unmodified; no wrap or arithmetic.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults and the FSM state encoding (ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_DONE=2'd2). The package is reused by the future DMA engine.
- One sub-module: rr_arbiter_2, a combinational 2-way winner select from REQ0, REQ1 and the pointer. The pointer register lives in the parent.

Test Plan:
- Single read, MEM_LAT=2, memory preloaded [0x123]=19'h5A5A5: REQ0=1, WE0=0, ADDR0=12'h123 → MEM_RD high 2 cycles with MEM_ADDR=0x123; ACK0 in cycle 3 after request with RDATA=19'h5A5A5; GNT1 never high.
- Single write: REQ1=1, WE1=1, ADDR1=12'hFFF, WDATA1=19'h7FFFF → MEM_WR 2 cycles, MEM_WDATA=19'h7FFFF; ACK1 pulse; subsequent port 0 read of 0xFFF returns 19'h7FFFF.
- Contention: REQ0 and REQ1 rise the same cycle from reset → port 0 served first; both held → grant order 0,1,0,1 across four accesses; ACKs spaced MEM_LAT+2=4 cycles.
- Withdraw: REQ0 dropped in the first ACCESS cycle → access completes, ACK0 still pulses once, FSM returns to IDLE.
- Reset mid-access: assert RST_N=0 while MEM_WR=1 → MEM_WR, GNT and ACK go 0 asynchronously; no ACK after release; next request from port 1 with both requesting is granted to port 0 (pointer reset).
- Parameter sweep MEM_LAT=1 and 15: strobe width equals MEM_LAT; ACK at request+MEM_LAT+1; RDATA sampled from the last strobe cycle.
